// File: rtl/i2c_bus_monitor.sv
// I2C pin front end: synchronises and deglitches SCL/SDA, detects START/STOP,
// tracks the transaction state and runs the SCL-low watchdog.
module i2c_bus_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3,
   parameter int SDA_DEL     = 2,
   parameter int WD_WIDTH    = 16
) (
   input  logic                sys_clk,
   input  logic                rst,
   input  logic                scl_in,
   input  logic                sda_in,
   input  logic                i2c_wd_en_n,
   input  logic                hif_select,
   input  logic [WD_WIDTH-1:0] wd_limit,
   output logic                hif_scl_del,
   output logic                hif_sda_del,
   output logic                hif_start,
   output logic                hif_stop,
   output logic                hif_active,
   output logic                hif_watchdog,
   output logic                hif_idle
);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_XFER} state_e;

   localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic [1:0]             line_sync;
   logic [1:0]             filt_q;
   logic [FCW-1:0]         fcnt_q [2];
   logic                   scl_f, sda_f, scl_q, sda_q;
   logic                   start_det, stop_det, scl_fall, scl_rise;
   logic                   wd_en, wd_expire;
   logic [WD_WIDTH-1:0]    wd_cnt_q, wd_cnt_d;
   state_e                 state_q, state_d;
   logic                   start_q, start_d, stop_q, stop_d, active_q, active_d;
   logic                   wd_q, wd_d, idle_q, idle_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      end
   end

   assign line_sync = {sda_sync_q[SYNC_STAGES-1], scl_sync_q[SYNC_STAGES-1]};

   // Index 0 is SCL, index 1 is SDA; a line flips on its FILT_LEN-th consecutive differing sample.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         filt_q    <= '1;
         fcnt_q[0] <= '0;
         fcnt_q[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (line_sync[i] != filt_q[i]) begin
               if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
                  filt_q[i] <= ~filt_q[i];
                  fcnt_q[i] <= '0;
               end else begin
                  fcnt_q[i] <= fcnt_q[i] + 1'b1;
               end
            end else begin
               fcnt_q[i] <= '0;
            end
         end
      end
   end

   assign scl_f = filt_q[0];
   assign sda_f = filt_q[1];

   generate
      if (SDA_DEL == 0) begin : g_no_dly
         assign hif_sda_del = sda_f;
      end else begin : g_dly
         logic [SDA_DEL-1:0] dly_q;
         always_ff @(posedge sys_clk) begin
            if (rst) begin
               dly_q <= '1;
            end else begin
               dly_q[0] <= sda_f;
               for (int i = 1; i < SDA_DEL; i++) dly_q[i] <= dly_q[i-1];
            end
         end
         assign hif_sda_del = dly_q[SDA_DEL-1];
      end
   endgenerate

   assign start_det = sda_q & ~sda_f & scl_q & scl_f;
   assign stop_det  = ~sda_q & sda_f & scl_q & scl_f;
   assign scl_fall  = scl_q & ~scl_f;
   assign scl_rise  = ~scl_q & scl_f;
   assign wd_en     = ~i2c_wd_en_n & ~hif_select & (wd_limit != '0);
   assign wd_expire = wd_en & (state_q == ST_XFER) & (wd_cnt_q >= wd_limit);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
         wd_cnt_q <= '0;
         start_q  <= 1'b0;
         stop_q   <= 1'b0;
         active_q <= 1'b0;
         wd_q     <= 1'b0;
         idle_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         scl_q    <= scl_f;
         sda_q    <= sda_f;
         wd_cnt_q <= wd_cnt_d;
         start_q  <= start_d;
         stop_q   <= stop_d;
         active_q <= active_d;
         wd_q     <= wd_d;
         idle_q   <= idle_d;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start_det) state_d = ST_START;
         ST_START: begin
            if (stop_det)      state_d = ST_IDLE;
            else if (scl_fall) state_d = ST_XFER;
         end
         ST_XFER: begin
            if (start_det)                  state_d = ST_START;
            else if (stop_det || wd_expire) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // START/STOP win over a same-cycle watchdog expiry.
   always_comb begin
      start_d  = (state_d == ST_START);
      active_d = (state_d != ST_IDLE);
      stop_d   = stop_det;
      wd_d     = wd_expire & ~start_det & ~stop_det;
      idle_d   = (state_q == ST_IDLE) & scl_f & sda_f;
      wd_cnt_d = wd_cnt_q;
      if (wd_expire || !wd_en || (state_q != ST_XFER) || scl_rise) begin
         wd_cnt_d = '0;
      end else if (!scl_f && (wd_cnt_q != '1)) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   assign hif_scl_del  = scl_f;
   assign hif_start    = start_q;
   assign hif_stop     = stop_q;
   assign hif_active   = active_q;
   assign hif_watchdog = wd_q;
   assign hif_idle     = idle_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Self-checking bench for i2c_bus_monitor: reference model from pin history,
// settled-state vector table, timing corner sequences and random pin activity.
module tb_i2c_bus_monitor;

   localparam int SYNC = 2;
   localparam int FILT = 3;
   localparam int SDEL = 2;
   localparam int WDW  = 16;
   localparam int unsigned WD_MAX = (1 << WDW) - 1;
   localparam int P_IDLE = 0, P_START = 1, P_XFER = 2;

   logic           sys_clk = 1'b0;
   logic           rst = 1'b1;
   logic           scl_in = 1'b1;
   logic           sda_in = 1'b1;
   logic           i2c_wd_en_n = 1'b1;
   logic           hif_select = 1'b0;
   logic [WDW-1:0] wd_limit = '0;
   logic           hif_scl_del, hif_sda_del, hif_start, hif_stop;
   logic           hif_active, hif_watchdog, hif_idle;
   logic [6:0]     dut_out;

   always #5 sys_clk = ~sys_clk;

   i2c_bus_monitor #(
      .SYNC_STAGES(SYNC), .FILT_LEN(FILT), .SDA_DEL(SDEL), .WD_WIDTH(WDW)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
      .i2c_wd_en_n(i2c_wd_en_n), .hif_select(hif_select), .wd_limit(wd_limit),
      .hif_scl_del(hif_scl_del), .hif_sda_del(hif_sda_del), .hif_start(hif_start),
      .hif_stop(hif_stop), .hif_active(hif_active), .hif_watchdog(hif_watchdog),
      .hif_idle(hif_idle)
   );

   assign dut_out = {hif_scl_del, hif_sda_del, hif_start, hif_stop, hif_active, hif_watchdog, hif_idle};

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference model: pin histories, sliding filter windows and a transaction phase.
   bit          m_sy_scl[$], m_sy_sda[$], m_win_scl[$], m_win_sda[$], m_dly[$];
   bit          m_scl_f, m_sda_f, m_scl_p, m_sda_p;
   int          m_phase;
   int unsigned m_low;
   bit [6:0]    m_exp;

   function automatic bit all_differ(input bit w[$], input bit f);
      foreach (w[i]) if (w[i] == f) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_sy_scl.delete(); m_sy_sda.delete(); m_win_scl.delete(); m_win_sda.delete(); m_dly.delete();
      repeat (SYNC) begin m_sy_scl.push_back(1'b1); m_sy_sda.push_back(1'b1); end
      repeat (FILT) begin m_win_scl.push_back(1'b1); m_win_sda.push_back(1'b1); end
      repeat (SDEL) m_dly.push_back(1'b1);
      m_scl_f = 1'b1; m_sda_f = 1'b1; m_scl_p = 1'b1; m_sda_p = 1'b1;
      m_phase = P_IDLE;
      m_low   = 0;
      m_exp   = 7'b1100001;
   endtask

   task automatic model_edge();
      bit start_c, stop_c, fall, rise, en, expire, wd, e_idle, old_sda, dly_out, si;
      int nphase;
      if (rst) begin
         model_reset();
         return;
      end
      start_c = m_sda_p && !m_sda_f && m_scl_p && m_scl_f;
      stop_c  = !m_sda_p && m_sda_f && m_scl_p && m_scl_f;
      fall    = m_scl_p && !m_scl_f;
      rise    = !m_scl_p && m_scl_f;
      en      = !i2c_wd_en_n && !hif_select && (wd_limit != 0);
      expire  = en && (m_phase == P_XFER) && (m_low >= int'(wd_limit));
      nphase  = m_phase;
      if (m_phase == P_IDLE && start_c) nphase = P_START;
      else if (m_phase == P_START) begin
         if (stop_c) nphase = P_IDLE;
         else if (fall) nphase = P_XFER;
      end else if (m_phase == P_XFER) begin
         if (start_c) nphase = P_START;
         else if (stop_c || expire) nphase = P_IDLE;
      end
      wd     = expire && !start_c && !stop_c;
      e_idle = (m_phase == P_IDLE) && m_scl_f && m_sda_f;
      if (expire || !en || m_phase != P_XFER || rise) m_low = 0;
      else if (!m_scl_f && m_low < WD_MAX) m_low++;
      m_scl_p = m_scl_f;
      m_sda_p = m_sda_f;
      old_sda = m_sda_f;
      si = m_sy_scl[0]; void'(m_win_scl.pop_front()); m_win_scl.push_back(si);
      if (all_differ(m_win_scl, m_scl_f)) m_scl_f = !m_scl_f;
      si = m_sy_sda[0]; void'(m_win_sda.pop_front()); m_win_sda.push_back(si);
      if (all_differ(m_win_sda, m_sda_f)) m_sda_f = !m_sda_f;
      void'(m_sy_scl.pop_front()); m_sy_scl.push_back(scl_in);
      void'(m_sy_sda.pop_front()); m_sy_sda.push_back(sda_in);
      if (SDEL == 0) dly_out = m_sda_f;
      else begin
         void'(m_dly.pop_front());
         m_dly.push_back(old_sda);
         dly_out = m_dly[0];
      end
      m_phase = nphase;
      m_exp = {m_scl_f, dly_out, nphase == P_START, stop_c, nphase != P_IDLE, wd, e_idle};
   endtask

   task automatic cycle();
      @(posedge sys_clk);
      model_edge();
      @(negedge sys_clk);
      cyc++;
      check($sformatf("model_c%0d", cyc), dut_out, m_exp);
   endtask

   task automatic hold(input int n);
      repeat (n) cycle();
   endtask

   task automatic bus_idle();
      scl_in = 1'b1; hold(12);
      sda_in = 1'b1; hold(12);
   endtask

   typedef struct {
      bit       scl;
      bit       sda;
      int       len;
      bit [6:0] exp;   // {scl_del, sda_del, start, stop, active, watchdog, idle}
   } vec_t;

   vec_t vecs [11];

   initial begin
      int lat, act_lat, s5, s6, stop_first, stop_cnt, act6, idle6, idle7;
      int changed, seen, dropped, wd_first, wd_cnt, wd_act, len;

      vecs[0]  = '{1, 1, 12, 7'b1100001};
      vecs[1]  = '{1, 0, 12, 7'b1010100};
      vecs[2]  = '{0, 0, 12, 7'b0000100};
      vecs[3]  = '{0, 1, 12, 7'b0100100};
      vecs[4]  = '{1, 1, 12, 7'b1100100};
      vecs[5]  = '{1, 0, 12, 7'b1010100};
      vecs[6]  = '{0, 0, 12, 7'b0000100};
      vecs[7]  = '{1, 0, 12, 7'b1000100};
      vecs[8]  = '{1, 1, 12, 7'b1100001};
      vecs[9]  = '{0, 1, 12, 7'b0100000};
      vecs[10] = '{1, 1, 12, 7'b1100001};

      model_reset();
      @(negedge sys_clk);
      rst = 1'b1;
      hold(3);
      check("reset", dut_out, 7'b1100001);
      rst = 1'b0;

      foreach (vecs[i]) begin
         scl_in = vecs[i].scl;
         sda_in = vecs[i].sda;
         hold(vecs[i].len);
         check($sformatf("vec%0d", i), dut_out, vecs[i].exp);
      end

      // START latency from the SDA pin
      lat = 0; act_lat = 0;
      sda_in = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cycle();
         if (hif_start && lat == 0) lat = k;
         if (hif_active && act_lat == 0) act_lat = k;
      end
      check("start_latency", lat, 6);
      check("active_latency", act_lat, 6);

      s5 = 0; s6 = 1;
      scl_in = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         cycle();
         if (k == 5) s5 = hif_start;
         if (k == 6) s6 = hif_start;
      end
      check("start_before_fall", s5, 1);
      check("start_after_fall", s6, 0);

      scl_in = 1'b1; hold(12);
      stop_first = 0; stop_cnt = 0; act6 = 1; idle6 = 1; idle7 = 0;
      sda_in = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         cycle();
         if (hif_stop) begin stop_cnt++; if (stop_first == 0) stop_first = k; end
         if (k == 6) begin act6 = hif_active; idle6 = hif_idle; end
         if (k == 7) idle7 = hif_idle;
      end
      check("stop_latency", stop_first, 6);
      check("stop_width", stop_cnt, 1);
      check("stop_active", act6, 0);
      check("stop_idle_p1", idle6, 0);
      check("stop_idle_p2", idle7, 1);

      // glitch rejection
      changed = 0;
      sda_in = 1'b0; cycle(); cycle();
      sda_in = 1'b1;
      for (int k = 0; k < 15; k++) begin
         cycle();
         if (dut_out != 7'b1100001) changed = 1;
      end
      check("glitch2_ignored", changed, 0);
      seen = 0;
      sda_in = 1'b0; hold(3);
      sda_in = 1'b1;
      for (int k = 0; k < 15; k++) begin
         cycle();
         if (hif_start) seen = 1;
      end
      check("glitch3_start", seen, 1);
      hold(12);

      // watchdog
      wd_limit = 10; i2c_wd_en_n = 1'b0; hif_select = 1'b0;
      sda_in = 1'b0; hold(12);
      wd_first = 0; wd_cnt = 0; wd_act = 1;
      scl_in = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         cycle();
         if (hif_watchdog) begin
            wd_cnt++;
            if (wd_first == 0) begin wd_first = k; wd_act = hif_active; end
         end
      end
      check("wd_latency", wd_first, 17);
      check("wd_width", wd_cnt, 1);
      check("wd_active", wd_act, 0);
      bus_idle();

      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) hif_select = 1'b1;
         else begin hif_select = 1'b0; wd_limit = 0; end
         sda_in = 1'b0; hold(12);
         seen = 0;
         scl_in = 1'b0;
         for (int k = 0; k < 40; k++) begin
            cycle();
            if (hif_watchdog) seen = 1;
         end
         check($sformatf("wd_off%0d_nopulse", pass), seen, 0);
         check($sformatf("wd_off%0d_active", pass), hif_active, 1);
         bus_idle();
      end

      // repeated START from XFER
      sda_in = 1'b0; hold(12);
      scl_in = 1'b0; hold(12);
      sda_in = 1'b1; hold(12);
      scl_in = 1'b1; hold(12);
      seen = 0; dropped = 0;
      sda_in = 1'b0;
      for (int k = 0; k < 12; k++) begin
         cycle();
         if (hif_start) seen = 1;
         if (!hif_active) dropped = 1;
      end
      check("rstart_start", seen, 1);
      check("rstart_active_held", dropped, 0);
      bus_idle();

      // SCL and SDA fall together
      seen = 0;
      scl_in = 1'b0; sda_in = 1'b0;
      for (int k = 0; k < 15; k++) begin
         cycle();
         if (hif_start || hif_active) seen = 1;
      end
      check("simul_no_start", seen, 0);
      bus_idle();

      // reset while the watchdog counter is at 5
      wd_limit = 20; i2c_wd_en_n = 1'b0;
      sda_in = 1'b0; hold(12);
      scl_in = 1'b0; hold(11);
      rst = 1'b1; cycle();
      check("rst_mid", dut_out, 7'b1100001);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 60; k++) begin
         cycle();
         if (hif_watchdog || hif_active) seen = 1;
      end
      check("rst_mid_no_wd", seen, 0);
      bus_idle();

      // random pin activity against the model
      wd_limit = 12; i2c_wd_en_n = 1'b0; hif_select = 1'b0;
      for (int s = 0; s < 400; s++) begin
         int a;
         a = $urandom_range(0, 9);
         if (a < 4) scl_in = ~scl_in;
         else if (a < 8) sda_in = ~sda_in;
         else if (a == 8) begin scl_in = ~scl_in; sda_in = ~sda_in; end
         if ($urandom_range(0, 40) == 0) begin
            wd_limit    = WDW'($urandom_range(0, 30));
            i2c_wd_en_n = ($urandom_range(0, 5) == 0);
            hif_select  = ($urandom_range(0, 5) == 0);
         end
         if ($urandom_range(0, 150) == 0) begin
            rst = 1'b1; cycle(); rst = 1'b0;
         end
         len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(15, 45)) : int'($urandom_range(1, 8));
         hold(len);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Oversampling front end for the I2C host interface on the system clock. Synchronises and deglitches the raw SCL/SDA pins, detects START/STOP conditions, tracks the transaction ACTIVE state, and runs the SCL-low watchdog. Its outputs (`hif_scl_del`, `hif_sda_del`, `hif_start`, `hif_stop`, `hif_active`, `hif_watchdog`, `hif_idle`) feed the reset/clock manager directly downstream.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops per pin (≥2).
- `FILT_LEN`, default 3: consecutive differing samples required to change a filtered line (≥1).
- `SDA_DEL`, default 2: extra sys_clk cycles of delay on `hif_sda_del` relative to the filtered SDA (≥0).
- `WD_WIDTH`, default 16: watchdog counter / limit width.

Ports:
- `sys_clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous, active-high.
- `scl_in` in 1: raw SCL pin, asynchronous.
- `sda_in` in 1: raw SDA pin, asynchronous.
- `i2c_wd_en_n` in 1: 0 = watchdog enabled.
- `hif_select` in 1: 0 = I2C mode. Watchdog runs only when this is 0.
- `wd_limit` in WD_WIDTH: timeout in sys_clk cycles. 0 = watchdog disabled.
- `hif_scl_del` out 1: filtered SCL.
- `hif_sda_del` out 1: filtered SDA, delayed by SDA_DEL cycles.
- `hif_start` out 1: START bit, a level signal.
- `hif_stop` out 1: one-cycle STOP pulse.
- `hif_active` out 1: transaction in progress.
- `hif_watchdog` out 1: one-cycle timeout pulse.
- `hif_idle` out 1: bus idle and no transaction.

## Operation
- **Synchroniser:** SYNC_STAGES flops per pin, reset to 1.
- **Filter:** one counter per line.
  - The counter increments while the synchronised value ≠ the filtered value, and clears otherwise.
  - The filtered value (`scl_f`, `sda_f`) flips on the edge where the FILT_LEN-th consecutive differing sample is seen; the counter clears at the same edge.
  - Filtered values reset to 1. A glitch shorter than FILT_LEN samples never propagates.
- **Outputs of the filter:**
  - `hif_scl_del` = `scl_f`.
  - `hif_sda_del` = `sda_f` through an SDA_DEL-deep shift register reset to 1. With SDA_DEL=0 it is a straight wire.
- **Condition detection:** uses `scl_f`, `sda_f` and their one-cycle-registered copies `scl_q`, `sda_q`.
  - START = `sda_q`=1, `sda_f`=0, `scl_q`=1, `scl_f`=1.
  - STOP = `sda_q`=0, `sda_f`=1, `scl_q`=1, `scl_f`=1.
  - If SCL and SDA change in the same cycle, no condition is detected.
- **FSM states:** IDLE (reset), START, XFER.
  - IDLE → START on START.
  - START → XFER on SCL falling edge (`scl_q`=1, `scl_f`=0).
  - START → IDLE on STOP.
  - XFER → START on repeated START.
  - XFER → IDLE on STOP or watchdog expiry.
- **FSM outputs:** registered, with these reset values.
  - `hif_start` = (state==START), reset 0.
  - `hif_active` = (state≠IDLE), reset 0.
  - `hif_stop` is high for exactly one cycle after a STOP is detected, in any state. Reset 0.
- **Watchdog:**
  - Enable = (`i2c_wd_en_n`==0) and (`hif_select`==0) and (`wd_limit`≠0).
  - The counter increments on each edge where the enable is set, state==XFER and `scl_f`==0. It saturates at all-ones.
  - It clears on an SCL rising edge, when not in XFER, or when the enable drops.
  - When counter ≥ `wd_limit`, `hif_watchdog` pulses high for 1 cycle, the FSM goes to IDLE, and the counter clears. The comparison uses the live `wd_limit`, so lowering it below the current count fires on the next edge.
  - `hif_watchdog` resets to 0.
- **Priority:** STOP beats watchdog in the same cycle: only `hif_stop` pulses. START beats watchdog in the same cycle.
- **Idle:** `hif_idle` is registered as (state==IDLE) & `scl_f` & `sda_f`, reset 1. Its rising edge marks the end of a transaction for the downstream shadow-register clock.
- **Reset mid-transaction:** on the next edge, all outputs return to their reset values and the filters return to 1.

## Timing
- Pin change → `scl_f`/`sda_f`: SYNC_STAGES + FILT_LEN cycles (5 with defaults). Add SDA_DEL more cycles for `hif_sda_del` (7 with defaults).
- `sda_f` fall with SCL high → `hif_start`/`hif_active` high 1 cycle later (6 cycles from pin with defaults).
- `scl_f` fall → `hif_start` low 1 cycle later.
- `sda_f` rise with SCL high → `hif_stop` high for cycle +1, `hif_active` low at +1, `hif_idle` high at +2.
- `scl_f` held low from cycle 0 in XFER → counter reaches `wd_limit` after `wd_limit` edges → `hif_watchdog` high for 1 cycle at edge `wd_limit`+1, with `hif_active` low the same cycle.

## Test plan
- **Reset:** hold `rst` for 3 cycles, pins high → `hif_scl_del`=`hif_sda_del`=1, `hif_start`=`hif_stop`=`hif_active`=`hif_watchdog`=0, `hif_idle`=1.
- **START/STOP, defaults:** drop `sda_in` with SCL high → `hif_start`/`hif_active` rise exactly 6 cycles later. Drop SCL → `hif_start` falls. Raise SCL, then SDA → single `hif_stop` pulse, `hif_active`=0, `hif_idle` rises 1 cycle after.
- **Glitch rejection:** 2-cycle low pulse on `sda_in` with SCL high → no change on any output. 3-cycle pulse → START detected.
- **Watchdog:** `wd_limit`=10, enabled, START then SCL held low → `hif_watchdog` one-cycle pulse after 10 SCL-low cycles, `hif_active`=0. Repeat with `hif_select`=1 or `wd_limit`=0 → no pulse, `hif_active` stays 1.
- **Repeated START and simultaneous edges:** in XFER, SDA falls with SCL high → `hif_start` re-asserts, `hif_active` stays 1. SCL and SDA fall on the same filtered cycle → no START.
- **Reset mid-operation:** assert `rst` during XFER with the counter at 5 → next edge all outputs at reset values. After release, SCL low does not trigger the watchdog until a new START is seen.
